// File: rtl/labfinal_soc_led_fx_driver.sv
// LED effects stage after the LED PIO: global PWM dimming and hardware blink,
// configured through a 4-register Avalon-MM slave. Reset values give pass-through.
module labfinal_soc_led_fx_driver #(
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned DIV_BITS = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_pattern,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] led_out
);

  localparam logic [PWM_BITS-1:0] DutyFull = '1;

  logic [2:0]          ctrl_q, ctrl_d;          // {pwm_en, blink_en, enable}
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DIV_BITS-1:0] period_q, period_d;
  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [WIDTH-1:0]    led_out_q, led_out_d;

  logic wr_en;
  logic restart;
  logic pwm_on;
  logic unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;
  assign restart      = wr_en && (address == 2'd0) && writedata[3];
  assign pwm_on       = (duty_q == DutyFull) || (pwm_cnt_q < duty_q);

  always_comb begin
    ctrl_d        = ctrl_q;
    duty_d        = duty_q;
    period_d      = period_q;
    pattern_d     = led_pattern;
    pwm_cnt_d     = pwm_cnt_q;
    div_cnt_d     = div_cnt_q;
    blink_phase_d = blink_phase_q;

    if (wr_en) begin
      case (address)
        2'd0:    ctrl_d   = writedata[2:0];
        2'd1:    duty_d   = writedata[PWM_BITS-1:0];
        2'd2:    period_d = writedata[DIV_BITS-1:0];
        default: ;
      endcase
    end

    // Restart wins over the normal counter update on the edge it is written.
    if (restart || !ctrl_q[2]) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end

    // Tick compares against the period already in effect (>= so lowering it fires at once).
    if (restart || !ctrl_q[1]) begin
      div_cnt_d     = '0;
      blink_phase_d = 1'b1;
    end else if (div_cnt_q >= period_q) begin
      div_cnt_d     = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_BITS'(1);
    end

    led_out_d = ctrl_q[0] ? (pattern_q & {WIDTH{blink_phase_q & pwm_on}}) : '0;
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[2:0]          = ctrl_q;
      2'd1: readdata[PWM_BITS-1:0] = duty_q;
      2'd2: readdata[DIV_BITS-1:0] = period_q;
      default: begin
        readdata[0]            = blink_phase_q;
        readdata[8 +: PWM_BITS] = pwm_cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= 3'b001;
      duty_q        <= '1;
      period_q      <= '0;
      pattern_q     <= '0;
      pwm_cnt_q     <= '0;
      div_cnt_q     <= '0;
      blink_phase_q <= 1'b1;
      led_out_q     <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      period_q      <= period_d;
      pattern_q     <= pattern_d;
      pwm_cnt_q     <= pwm_cnt_d;
      div_cnt_q     <= div_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_labfinal_soc_led_fx_driver.sv
// Directed bench for labfinal_soc_led_fx_driver: one task per feature, inline checks.
// Inputs change and outputs are sampled on the falling edge.
module tb_labfinal_soc_led_fx_driver;

  logic        clk;
  logic        reset;
  logic [13:0] led_pattern;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [13:0] led_out;

  int errors = 0;
  int checks = 0;

  labfinal_soc_led_fx_driver #(
    .WIDTH(14), .PWM_BITS(8), .DIV_BITS(24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_pattern(led_pattern),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    checks++; if (led_out !== 14'h0) begin errors++;
      $display("FAIL reset_led: got %h expected %h", led_out, 14'h0); end
    read_reg(2'd0, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL reset_ctrl: got %h expected %h", d, 32'h1); end
    read_reg(2'd1, d);
    checks++; if (d !== 32'hFF) begin errors++;
      $display("FAIL reset_duty: got %h expected %h", d, 32'hFF); end
    read_reg(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL reset_period: got %h expected %h", d, 32'h0); end
    read_reg(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_pass_through;
    led_pattern = 14'h2A5A;
    step(1);
    checks++; if (led_out !== 14'h0) begin errors++;
      $display("FAIL pass_early: got %h expected %h", led_out, 14'h0); end
    step(1);
    checks++; if (led_out !== 14'h2A5A) begin errors++;
      $display("FAIL pass_lat2: got %h expected %h", led_out, 14'h2A5A); end
  endtask

  task automatic test_write_qualify;
    logic [31:0] d;
    // write_n low without chipselect must not write
    address = 2'd1; writedata = 32'h11; chipselect = 1'b0; write_n = 1'b0;
    step(1);
    write_n = 1'b1;
    read_reg(2'd1, d);
    checks++; if (d !== 32'hFF) begin errors++;
      $display("FAIL no_cs_write: got %h expected %h", d, 32'hFF); end
    write_reg(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL status_ro: got %h expected %h", d, 32'h1); end
    write_reg(2'd2, 32'hFFFF_FFFF);
    read_reg(2'd2, d);
    checks++; if (d !== 32'h00FF_FFFF) begin errors++;
      $display("FAIL period_mask: got %h expected %h", d, 32'h00FF_FFFF); end
    write_reg(2'd1, 32'h123);
    read_reg(2'd1, d);
    checks++; if (d !== 32'h23) begin errors++;
      $display("FAIL duty_mask: got %h expected %h", d, 32'h23); end
    write_reg(2'd0, 32'hFFFF_FFF9);
    read_reg(2'd0, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL ctrl_mask: got %h expected %h", d, 32'h1); end
    write_reg(2'd1, 32'hFF);
    write_reg(2'd2, 32'h0);
  endtask

  task automatic test_disable;
    led_pattern = 14'h3FFF;
    step(2);
    write_reg(2'd0, 32'h0);
    checks++; if (led_out !== 14'h3FFF) begin errors++;
      $display("FAIL dis_edge1: got %h expected %h", led_out, 14'h3FFF); end
    step(1);
    checks++; if (led_out !== 14'h0) begin errors++;
      $display("FAIL dis_edge2: got %h expected %h", led_out, 14'h0); end
    write_reg(2'd0, 32'h1);
    checks++; if (led_out !== 14'h0) begin errors++;
      $display("FAIL en_edge1: got %h expected %h", led_out, 14'h0); end
    step(1);
    checks++; if (led_out !== 14'h3FFF) begin errors++;
      $display("FAIL en_edge2: got %h expected %h", led_out, 14'h3FFF); end
  endtask

  task automatic test_blink;
    logic [31:0] d;
    logic [11:0] led_on;
    logic [11:0] phase;
    logic [13:0] exp_led;
    led_on = 12'b1111_0000_1111;
    phase  = 12'b0111_1000_0111;
    led_pattern = 14'h00FF;
    write_reg(2'd2, 32'd3);
    write_reg(2'd0, 32'h3);
    for (int k = 0; k < 12; k++) begin
      step(1);
      exp_led = led_on[k] ? 14'h00FF : 14'h0;
      checks++; if (led_out !== exp_led) begin errors++;
        $display("FAIL blink_led[%0d]: got %h expected %h", k + 1, led_out, exp_led); end
      read_reg(2'd3, d);
      checks++; if (d[0] !== phase[k]) begin errors++;
        $display("FAIL blink_phase[%0d]: got %b expected %b", k + 1, d[0], phase[k]); end
    end
    write_reg(2'd0, 32'h1);
    step(2);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b1) begin errors++;
      $display("FAIL blink_off_phase: got %b expected %b", d[0], 1'b1); end
    checks++; if (led_out !== 14'h00FF) begin errors++;
      $display("FAIL blink_off_led: got %h expected %h", led_out, 14'h00FF); end
  endtask

  task automatic test_pwm;
    int hi;
    logic [31:0] duty_list [3];
    int          exp_hi [3];
    duty_list = '{32'h40, 32'h0, 32'hFF};
    exp_hi    = '{64, 0, 256};
    led_pattern = 14'h0001;
    write_reg(2'd1, 32'h40);
    write_reg(2'd0, 32'h5);
    for (int t = 0; t < 3; t++) begin
      if (t != 0) write_reg(2'd1, duty_list[t]);
      step(4);
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        step(1);
        if (led_out[0] === 1'b1) hi++;
      end
      checks++; if (hi != exp_hi[t]) begin errors++;
        $display("FAIL pwm_duty_%0h: got %0d expected %0d", duty_list[t], hi, exp_hi[t]); end
    end
  endtask

  task automatic test_period_boundary;
    logic [31:0] d;
    write_reg(2'd0, 32'h1);
    write_reg(2'd2, 32'd100);
    write_reg(2'd0, 32'h3);
    step(50);
    write_reg(2'd2, 32'd10);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b1) begin errors++;
      $display("FAIL bnd_pre_tick: got %b expected %b", d[0], 1'b1); end
    read_reg(2'd2, d);
    checks++; if (d !== 32'd10) begin errors++;
      $display("FAIL bnd_period: got %h expected %h", d, 32'd10); end
    step(1);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b0) begin errors++;
      $display("FAIL bnd_tick_now: got %b expected %b", d[0], 1'b0); end
    step(10);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b0) begin errors++;
      $display("FAIL bnd_hold10: got %b expected %b", d[0], 1'b0); end
    step(1);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b1) begin errors++;
      $display("FAIL bnd_tick11: got %b expected %b", d[0], 1'b1); end
    step(10);
    // write a longer period exactly on the tick edge; the old period still fires it
    write_reg(2'd2, 32'd20);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b0) begin errors++;
      $display("FAIL bnd_tick_old_period: got %b expected %b", d[0], 1'b0); end
    step(20);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b0) begin errors++;
      $display("FAIL bnd_new_hold: got %b expected %b", d[0], 1'b0); end
    step(1);
    read_reg(2'd3, d);
    checks++; if (d[0] !== 1'b1) begin errors++;
      $display("FAIL bnd_new_tick: got %b expected %b", d[0], 1'b1); end
  endtask

  task automatic test_restart;
    logic [31:0] d;
    write_reg(2'd1, 32'h80);
    write_reg(2'd2, 32'd3);
    write_reg(2'd0, 32'h7);
    step(5);
    write_reg(2'd0, 32'hF);
    read_reg(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL restart_status: got %h expected %h", d, 32'h1); end
    read_reg(2'd0, d);
    checks++; if (d !== 32'h7) begin errors++;
      $display("FAIL restart_ctrl: got %h expected %h", d, 32'h7); end
    step(1);
    read_reg(2'd3, d);
    checks++; if (d !== 32'h101) begin errors++;
      $display("FAIL restart_run: got %h expected %h", d, 32'h101); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    reset = 1'b1;
    led_pattern = 14'h1234;
    step(1);
    reset = 1'b0;
    checks++; if (led_out !== 14'h0) begin errors++;
      $display("FAIL rmid_led: got %h expected %h", led_out, 14'h0); end
    read_reg(2'd0, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL rmid_ctrl: got %h expected %h", d, 32'h1); end
    read_reg(2'd1, d);
    checks++; if (d !== 32'hFF) begin errors++;
      $display("FAIL rmid_duty: got %h expected %h", d, 32'hFF); end
    read_reg(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL rmid_period: got %h expected %h", d, 32'h0); end
    read_reg(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL rmid_status: got %h expected %h", d, 32'h1); end
    step(1);
    checks++; if (led_out !== 14'h0) begin errors++;
      $display("FAIL rmid_lat1: got %h expected %h", led_out, 14'h0); end
    step(1);
    checks++; if (led_out !== 14'h1234) begin errors++;
      $display("FAIL rmid_lat2: got %h expected %h", led_out, 14'h1234); end
  endtask

  initial begin
    reset       = 1'b1;
    led_pattern = '0;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    test_reset();
    test_pass_through();
    test_write_qualify();
    test_disable();
    test_blink();
    test_pwm();
    test_period_boundary();
    test_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
